vga_timing_generator: RTL and testbench

- Produces 640x480 @ 60 Hz VGA timing from the 25 MHz pixel clock.
- Presents the current pixel coordinate (x, y) to img_generator and samples the 3-bit color it returns.
- Drives the VGA connector: hsync, vsync, and a 3-bit RGB value that is blanked outside the active area.
- Delays sync and blank internally so they stay aligned with img_generator's color pipeline, and emits a once-per-frame tick for game logic.

---
 rtl/vga_timing_generator_pkg.sv | 33 +++
 rtl/sync_delay.sv | 33 +++
 rtl/vga_timing_generator.sv | 119 +++++++++++
 tb/tb_vga_timing_generator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_generator_pkg.sv
// Shared constants and payload types for the 640x480@60 VGA timing generator.
// Default geometry is 640x480 @ 60 Hz from a 25 MHz pixel clock.
package vga_timing_generator_pkg;

  localparam int unsigned FRAME_WIDTH  = 640;
  localparam int unsigned FRAME_HEIGHT = 480;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL      = FRAME_WIDTH + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL      = FRAME_HEIGHT + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned HSYNC_START  = FRAME_WIDTH + H_FP_DEF;
  localparam int unsigned HSYNC_END    = HSYNC_START + H_SYNC_DEF - 1;
  localparam int unsigned VSYNC_START  = FRAME_HEIGHT + V_FP_DEF;
  localparam int unsigned VSYNC_END    = VSYNC_START + V_SYNC_DEF - 1;

  localparam int unsigned CNT_W              = 10;
  localparam int unsigned COORD_W            = 12;
  localparam int unsigned RGB_W              = 3;
  localparam int unsigned MAX_COLOR_LATENCY  = 4;

  // Per-pixel control bits that travel alongside the colour pipeline.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } align_t;

endpackage

// File: rtl/sync_delay.sv
// DEPTH x WIDTH shift register with async active-low reset; wire-through at DEPTH=0.
module sync_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_q <= '0;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: counters, coordinate presentation, colour-aligned sync/blank and frame tick.
module vga_timing_generator
  import vga_timing_generator_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = FRAME_WIDTH,
  parameter int unsigned H_FP            = H_FP_DEF,
  parameter int unsigned H_SYNC          = H_SYNC_DEF,
  parameter int unsigned H_BP            = H_BP_DEF,
  parameter int unsigned V_ACTIVE        = FRAME_HEIGHT,
  parameter int unsigned V_FP            = V_FP_DEF,
  parameter int unsigned V_SYNC          = V_SYNC_DEF,
  parameter int unsigned V_BP            = V_BP_DEF,
  parameter int unsigned COLOR_LATENCY   = 1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               CLOCK_25,
  input  logic               RESET_N,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active,
  input  logic [RGB_W-1:0]   color,
  output logic [RGB_W-1:0]   vga_rgb,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               frame_tick
);

  localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW;

  if (COLOR_LATENCY > MAX_COLOR_LATENCY) begin : g_bad_latency
    $error("vga_timing_generator: COLOR_LATENCY must be 0..4");
  end

  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               tick_q, tick_d;
  align_t             p_q, p_d;
  align_t             dly;
  logic [RGB_W-1:0]   rgb_q;
  logic               hs_q, vs_q;
  logic               h_act, v_act;

  // Counter advance and stage-P decode from the current counter values.
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CNT_W'(HT - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == CNT_W'(VT - 1)) ? '0 : v_cnt_q + CNT_W'(1);
    end

    h_act    = h_cnt_q < CNT_W'(H_ACTIVE);
    v_act    = v_cnt_q < CNT_W'(V_ACTIVE);
    x_d      = h_act ? COORD_W'(h_cnt_q) + COORD_W'(1) : '0;
    y_d      = v_act ? COORD_W'(v_cnt_q) + COORD_W'(1) : '0;
    tick_d   = (h_cnt_q == '0) && (v_cnt_q == CNT_W'(V_ACTIVE));
    p_d.active = h_act && v_act;
    p_d.hs   = (h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q <= CNT_W'(HS_END));
    p_d.vs   = (v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q <= CNT_W'(VS_END));
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      tick_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tick_q  <= tick_d;
      p_q     <= p_d;
    end
  end

  sync_delay #(
    .DEPTH (COLOR_LATENCY),
    .WIDTH ($bits(align_t))
  ) u_sync_delay (
    .clk   (CLOCK_25),
    .rst_n (RESET_N),
    .d_i   (p_q),
    .q_o   (dly)
  );

  // Output register: colour is gated by the blank flag aligned to it.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_q <= '0;
      hs_q  <= SYNC_IDLE;
      vs_q  <= SYNC_IDLE;
    end else begin
      rgb_q <= dly.active ? color : '0;
      hs_q  <= dly.hs ^ SYNC_IDLE;
      vs_q  <= dly.vs ^ SYNC_IDLE;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign active     = p_q.active;
  assign frame_tick = tick_q;
  assign vga_rgb    = rgb_q;
  assign vga_hsync  = hs_q;
  assign vga_vsync  = vs_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Randomized bench: four generator instances checked cycle-by-cycle against a raster-position model.
module tb_vga_timing_generator;

  localparam int NDUT = 4;
  // Reduced geometry so several whole frames fit in a short run.
  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVA = 8,  SVF = 2, SVS = 2, SVB = 3;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, lat;
    bit low;
  } geom_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] x_w [NDUT];
  logic [11:0] y_w [NDUT];
  logic        act_w [NDUT];
  logic [2:0]  color_r [NDUT];
  logic [2:0]  rgb_w [NDUT];
  logic        hs_w [NDUT];
  logic        vs_w [NDUT];
  logic        tick_w [NDUT];

  geom_t      g [NDUT];
  logic [2:0] lut [64];
  int         n;
  int         n_total = 0;
  int         n_bad = 0;
  int         last_tick [NDUT];
  int         hrun [NDUT];
  int         vrun [NDUT];

  always #20 clk = ~clk;

  vga_timing_generator #(.COLOR_LATENCY(1), .SYNC_ACTIVE_LOW(1'b1)) u_d0 (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(x_w[0]), .y(y_w[0]), .active(act_w[0]),
    .color(color_r[0]), .vga_rgb(rgb_w[0]), .vga_hsync(hs_w[0]), .vga_vsync(vs_w[0]),
    .frame_tick(tick_w[0]));

  vga_timing_generator #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .COLOR_LATENCY(0), .SYNC_ACTIVE_LOW(1'b1)) u_d1 (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(x_w[1]), .y(y_w[1]), .active(act_w[1]),
    .color(color_r[1]), .vga_rgb(rgb_w[1]), .vga_hsync(hs_w[1]), .vga_vsync(vs_w[1]),
    .frame_tick(tick_w[1]));

  vga_timing_generator #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .COLOR_LATENCY(1), .SYNC_ACTIVE_LOW(1'b0)) u_d2 (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(x_w[2]), .y(y_w[2]), .active(act_w[2]),
    .color(color_r[2]), .vga_rgb(rgb_w[2]), .vga_hsync(hs_w[2]), .vga_vsync(vs_w[2]),
    .frame_tick(tick_w[2]));

  vga_timing_generator #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .COLOR_LATENCY(3), .SYNC_ACTIVE_LOW(1'b1)) u_d3 (
    .CLOCK_25(clk), .RESET_N(rst_n), .x(x_w[3]), .y(y_w[3]), .active(act_w[3]),
    .color(color_r[3]), .vga_rgb(rgb_w[3]), .vga_hsync(hs_w[3]), .vga_vsync(vs_w[3]),
    .frame_tick(tick_w[3]));

  function automatic int htot(geom_t gg);
    return gg.ha + gg.hf + gg.hs + gg.hb;
  endfunction

  function automatic int flen(geom_t gg);
    return htot(gg) * (gg.va + gg.vf + gg.vs + gg.vb);
  endfunction

  // Raster position index p (0 = top-left) -> horizontal/vertical position.
  function automatic int hpos(geom_t gg, int p);
    return (p % flen(gg)) % htot(gg);
  endfunction

  function automatic int vpos(geom_t gg, int p);
    return (p % flen(gg)) / htot(gg);
  endfunction

  function automatic bit is_act(geom_t gg, int p);
    return p >= 0 && hpos(gg, p) < gg.ha && vpos(gg, p) < gg.va;
  endfunction

  // After edge k (k>=1) of the frame the presentation stage shows position k-1.
  function automatic int exp_x(geom_t gg, int k);
    if (k < 1 || hpos(gg, k - 1) >= gg.ha) return 0;
    return hpos(gg, k - 1) + 1;
  endfunction

  function automatic int exp_y(geom_t gg, int k);
    if (k < 1 || vpos(gg, k - 1) >= gg.va) return 0;
    return vpos(gg, k - 1) + 1;
  endfunction

  function automatic int exp_tick(geom_t gg, int k);
    return (k >= 1 && ((k - 1) % flen(gg)) == gg.va * htot(gg)) ? 1 : 0;
  endfunction

  // Pins after edge k show the position presented lat+1 edges earlier.
  function automatic int exp_hs(geom_t gg, int k);
    int p = k - gg.lat - 2;
    bit raw = p >= 0 && hpos(gg, p) >= gg.ha + gg.hf && hpos(gg, p) < gg.ha + gg.hf + gg.hs;
    return (gg.low ? !raw : raw) ? 1 : 0;
  endfunction

  function automatic int exp_vs(geom_t gg, int k);
    int p = k - gg.lat - 2;
    bit raw = p >= 0 && vpos(gg, p) >= gg.va + gg.vf && vpos(gg, p) < gg.va + gg.vf + gg.vs;
    return (gg.low ? !raw : raw) ? 1 : 0;
  endfunction

  function automatic int exp_rgb(geom_t gg, int k);
    int p = k - gg.lat - 2;
    return is_act(gg, p) ? int'(lut[p % 64]) : 0;
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  task automatic check_all(input int k);
    for (int d = 0; d < NDUT; d++) begin
      check_val($sformatf("x%0d", d), int'(x_w[d]), exp_x(g[d], k));
      check_val($sformatf("y%0d", d), int'(y_w[d]), exp_y(g[d], k));
      check_val($sformatf("active%0d", d), int'(act_w[d]),
                (exp_x(g[d], k) != 0 && exp_y(g[d], k) != 0) ? 1 : 0);
      check_val($sformatf("tick%0d", d), int'(tick_w[d]), exp_tick(g[d], k));
      check_val($sformatf("rgb%0d", d), int'(rgb_w[d]), exp_rgb(g[d], k));
      check_val($sformatf("hsync%0d", d), int'(hs_w[d]), exp_hs(g[d], k));
      check_val($sformatf("vsync%0d", d), int'(vs_w[d]), exp_vs(g[d], k));
    end
  endtask

  // Colour for the edge k+1 sample belongs to position k-lat-1; blanking gets noise.
  task automatic drive_colors(input int k);
    for (int d = 0; d < NDUT; d++) begin
      int p = k - g[d].lat - 1;
      color_r[d] = is_act(g[d], p) ? lut[p % 64] : 3'($urandom);
    end
  endtask

  task automatic clear_track();
    for (int d = 0; d < NDUT; d++) begin
      last_tick[d] = -1;
      hrun[d] = 0;
      vrun[d] = 0;
    end
  endtask

  // Whole-interval properties: tick period and sync pulse widths.
  task automatic track(input int k);
    for (int d = 0; d < NDUT; d++) begin
      bit ha = g[d].low ? !hs_w[d] : hs_w[d];
      bit va = g[d].low ? !vs_w[d] : vs_w[d];
      if (tick_w[d]) begin
        if (last_tick[d] >= 0)
          check_val($sformatf("tick_period%0d", d), k - last_tick[d], flen(g[d]));
        last_tick[d] = k;
      end
      if (ha) hrun[d]++;
      else if (hrun[d] > 0) begin
        check_val($sformatf("hs_width%0d", d), hrun[d], g[d].hs);
        hrun[d] = 0;
      end
      if (va) vrun[d]++;
      else if (vrun[d] > 0) begin
        check_val($sformatf("vs_width%0d", d), vrun[d], g[d].vs * htot(g[d]));
        vrun[d] = 0;
      end
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check_all(n);
      track(n);
      drive_colors(n);
    end
  endtask

  initial begin
    g[0] = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, lat:1, low:1'b1};
    g[1] = '{ha:SHA, hf:SHF, hs:SHS, hb:SHB, va:SVA, vf:SVF, vs:SVS, vb:SVB, lat:0, low:1'b1};
    g[2] = '{ha:SHA, hf:SHF, hs:SHS, hb:SHB, va:SVA, vf:SVF, vs:SVS, vb:SVB, lat:1, low:1'b0};
    g[3] = '{ha:SHA, hf:SHF, hs:SHS, hb:SHB, va:SVA, vf:SVF, vs:SVS, vb:SVB, lat:3, low:1'b1};
    for (int i = 0; i < 64; i++) lut[i] = 3'($urandom);
    for (int d = 0; d < NDUT; d++) color_r[d] = 3'($urandom);
    clear_track();
    n = 0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    check_all(0);

    rst_n = 1'b1;
    drive_colors(0);
    run(2410 + int'($urandom_range(0, 200)));

    // Asynchronous reset between edges, mid-frame.
    #2;
    rst_n = 1'b0;
    n = 0;
    #1;
    check_all(0);
    clear_track();
    repeat (2) @(negedge clk);
    check_all(0);

    rst_n = 1'b1;
    drive_colors(0);
    run(1200);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
